// File: rtl/operand_stack.sv
// operand_stack: LIFO data stack for the processor datapath.
// Accepts at most one of push/pop/replace per cycle; exposes top/next-on-stack
// combinationally, plus empty/full status and sticky error flags.
module operand_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              replace,
    input  logic              clear_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              illegal
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_m1;
    logic [CNT_W-1:0]  cnt_m2;

    logic multi_cmd;
    logic do_push;
    logic do_pop;
    logic do_replace;
    logic ovf_evt;
    logic unf_evt;

    // Command decode: legal single commands and the error events they raise
    always_comb begin
        multi_cmd  = (push & pop) | (push & replace) | (pop & replace);
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (!multi_cmd) begin
            if (push) begin
                if (cnt_q < DEPTH_C) do_push = 1'b1;
                else                 ovf_evt = 1'b1;
            end
            if (pop) begin
                if (cnt_q >= ONE_C) do_pop  = 1'b1;
                else                unf_evt = 1'b1;
            end
            if (replace) begin
                if (cnt_q >= TWO_C) do_replace = 1'b1;
                else                unf_evt    = 1'b1;
            end
        end
    end

    assign cnt_m1 = cnt_q - ONE_C;
    assign cnt_m2 = cnt_q - TWO_C;

    // Storage writes; contents are never cleared since reads are masked by count
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push)
                mem[cnt_q[AW-1:0]] <= data_in;
            else if (do_replace)
                mem[cnt_m2[AW-1:0]] <= data_in;
        end
    end

    // Entry count; replace is a net decrement of one
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (do_push)
            cnt_q <= cnt_q + ONE_C;
        else if (do_pop || do_replace)
            cnt_q <= cnt_m1;
    end

    // Sticky error flags; a same-cycle error overrides clear_err
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clear_err) | ovf_evt;
            underflow <= (underflow & ~clear_err) | unf_evt;
            illegal   <= (illegal   & ~clear_err) | multi_cmd;
        end
    end

    // Masked read ports and status
    always_comb begin
        tos = '0;
        nos = '0;
        if (cnt_q >= ONE_C) tos = mem[cnt_m1[AW-1:0]];
        if (cnt_q >= TWO_C) nos = mem[cnt_m2[AW-1:0]];
    end

    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack.
module tb_operand_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic              replace;
    logic              clear_err;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] tos;
    logic [DATA_W-1:0] nos;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              illegal;

    int errors = 0;
    int checks = 0;

    operand_stack #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .replace  (replace),
        .clear_err(clear_err),
        .data_in  (data_in),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic rs, input logic pu, input logic po, input logic rp,
                        input logic ce, input logic [DATA_W-1:0] d);
        reset = rs; push = pu; pop = po; replace = rp; clear_err = ce; data_in = d;
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0; replace = 1'b0; clear_err = 1'b0; data_in = '0;
    endtask

    task automatic check_flags(input string tag, input logic o, input logic u, input logic i);
        check({tag, ".overflow"},  32'(overflow),  32'(o));
        check({tag, ".underflow"}, 32'(underflow), 32'(u));
        check({tag, ".illegal"},   32'(illegal),   32'(i));
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; replace = 1'b0; clear_err = 1'b0; data_in = '0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset state
        check("rst.count", 32'(count), 0);
        check("rst.empty", 32'(empty), 1);
        check("rst.full",  32'(full),  0);
        check("rst.tos",   32'(tos),   0);
        check("rst.nos",   32'(nos),   0);
        check_flags("rst", 0, 0, 0);

        // Single push
        step(0, 1, 0, 0, 0, 8'd5);
        check("push5.tos",   32'(tos),   5);
        check("push5.count", 32'(count), 1);
        check("push5.empty", 32'(empty), 0);
        check("push5.nos",   32'(nos),   0);

        // Push 7 then pop twice
        step(0, 1, 0, 0, 0, 8'd7);
        check("push7.tos", 32'(tos), 7);
        check("push7.nos", 32'(nos), 5);
        step(0, 0, 1, 0, 0, 0);
        check("pop1.tos",   32'(tos),   5);
        check("pop1.count", 32'(count), 1);
        step(0, 0, 1, 0, 0, 0);
        check("pop2.empty",     32'(empty),     1);
        check("pop2.tos",       32'(tos),       0);
        check("pop2.underflow", 32'(underflow), 0);

        // Pop on empty, idle hold, then clear
        step(0, 0, 1, 0, 0, 0);
        check("popE.underflow", 32'(underflow), 1);
        check("popE.count",     32'(count),     0);
        step(0, 0, 0, 0, 0, 0);
        check("idle.underflow", 32'(underflow), 1);
        step(0, 0, 0, 0, 1, 0);
        check("clr1.underflow", 32'(underflow), 0);

        // Fill to DEPTH
        for (int unsigned i = 1; i <= 16; i++) step(0, 1, 0, 0, 0, DATA_W'(i));
        check("fill.full",  32'(full),  1);
        check("fill.tos",   32'(tos),   16);
        check("fill.nos",   32'(nos),   15);
        check("fill.count", 32'(count), 16);

        // Overflow
        step(0, 1, 0, 0, 0, 8'd17);
        check("ovf.count",    32'(count),    16);
        check("ovf.tos",      32'(tos),      16);
        check("ovf.overflow", 32'(overflow), 1);

        // Error in same cycle as clear_err wins
        step(0, 1, 0, 0, 1, 8'd18);
        check("ovfclr.overflow", 32'(overflow), 1);
        check("ovfclr.tos",      32'(tos),      16);
        step(0, 0, 0, 0, 1, 0);
        check("clr2.overflow", 32'(overflow), 0);
        check("clr2.full",     32'(full),     1);

        // Replace
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 8'd3);
        step(0, 1, 0, 0, 0, 8'd4);
        step(0, 0, 0, 1, 0, 8'd12);
        check("rep.count", 32'(count), 1);
        check("rep.tos",   32'(tos),   12);
        check("rep.nos",   32'(nos),   0);
        step(0, 0, 0, 1, 0, 8'd99);
        check("repU.underflow", 32'(underflow), 1);
        check("repU.tos",       32'(tos),       12);
        check("repU.count",     32'(count),     1);

        // Illegal: push+pop
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 8'd9);
        step(0, 1, 1, 0, 0, 8'd33);
        check_flags("ill", 0, 0, 1);
        check("ill.count", 32'(count), 1);
        check("ill.tos",   32'(tos),   9);

        // Illegal: pop+replace also leaves the stack alone
        step(0, 0, 1, 1, 0, 8'd44);
        check("ill2.count", 32'(count), 1);
        check("ill2.tos",   32'(tos),   9);

        // Reset wins over same-cycle push
        step(0, 1, 0, 0, 0, 8'd5);
        step(0, 1, 0, 0, 0, 8'd6);
        check("pre.count", 32'(count), 3);
        check("pre.nos",   32'(nos),   5);
        step(1, 1, 0, 0, 0, 8'd77);
        check("rstp.count", 32'(count), 0);
        check("rstp.empty", 32'(empty), 1);
        check("rstp.tos",   32'(tos),   0);
        check_flags("rstp", 0, 0, 0);

        // Stale storage stays hidden after reset
        step(0, 1, 0, 0, 0, 8'd42);
        check("post.tos", 32'(tos), 42);
        check("post.nos", 32'(nos), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
